// File: rtl/maxpooling_div_62ns_32s_64_seq.sv
// Sequential restoring divider: unsigned dividend / signed divisor, one quotient bit per ce edge.
// Produces a signed quotient truncated toward zero and a non-negative remainder.
module maxpooling_div_62ns_32s_64_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 62,
  parameter int unsigned din1_WIDTH = 32,
  parameter int unsigned dout_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz
);

  localparam int unsigned CntW = $clog2(din0_WIDTH + 1);
  localparam int unsigned PrW  = din1_WIDTH + 1;

  // The quotient must hold a negated din0_WIDTH-bit magnitude without overflow.
  if (dout_WIDTH < din0_WIDTH + 1 || ID > 32'h7FFF_FFFF) begin : g_bad_param
    $error("maxpooling_div: unusable parameter set");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                state_q, state_d;
  logic [din0_WIDTH-1:0] dvd_q, dvd_d;
  logic [din0_WIDTH-1:0] q_q, q_d;
  logic [PrW-1:0]        mag_q, mag_d;
  logic [PrW-1:0]        pr_q, pr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic                  zero_q, zero_d;
  logic                  done_q, done_d;
  logic [dout_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [PrW-1:0]        din1_ext;
  logic [PrW:0]          pr_shift;
  logic                  pr_ge;
  logic [dout_WIDTH-1:0] q_ext;

  assign din1_ext = {din1[din1_WIDTH-1], din1};
  assign pr_shift = {pr_q, dvd_q[din0_WIDTH-1]};
  assign pr_ge    = pr_shift >= {1'b0, mag_q};
  assign q_ext    = {{(dout_WIDTH - din0_WIDTH){1'b0}}, q_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    q_d     = q_q;
    mag_d   = mag_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = din0;
          sign_d  = din1[din1_WIDTH-1];
          // One extra bit so that the most negative divisor yields a positive magnitude.
          mag_d   = din1[din1_WIDTH-1] ? -din1_ext : din1_ext;
          pr_d    = '0;
          q_d     = '0;
          cnt_d   = CntW'(din0_WIDTH);
          zero_d  = (din1 == '0);
          state_d = (din1 == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        dvd_d = {dvd_q[din0_WIDTH-2:0], 1'b0};
        pr_d  = pr_ge ? PrW'(pr_shift - {1'b0, mag_q}) : PrW'(pr_shift);
        q_d   = {q_q[din0_WIDTH-2:0], pr_ge};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = dvd_q[din1_WIDTH-1:0];
          dbz_d  = 1'b1;
        end else begin
          quot_d = sign_q ? -q_ext : q_ext;
          rem_d  = pr_q[din1_WIDTH-1:0];
          dbz_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      q_q     <= '0;
      mag_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      q_q     <= q_d;
      mag_q   <= mag_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = done_q;
  assign quot  = quot_q;
  assign rem   = rem_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_maxpooling_div_62ns_32s_64_seq.sv
// Bench for the sequential divider: directed cases with literal expectations plus randomized
// operands and clock-enable, all compared every cycle against an arithmetic reference model.
module tb_maxpooling_div_62ns_32s_64_seq;

  localparam int Lat = 64;

  typedef struct packed {
    logic [63:0] q;
    logic [31:0] r;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [61:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic        ready;
  logic        done;
  logic [63:0] quot;
  logic [31:0] rem;
  logic        dbz;

  int errors = 0;
  int checks = 0;
  bit rand_ce = 1'b0;

  maxpooling_div_62ns_32s_64_seq #(
    .ID        (1),
    .din0_WIDTH(62),
    .din1_WIDTH(32),
    .dout_WIDTH(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .start(start),
    .din0 (din0),
    .din1 (din1),
    .ready(ready),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // Plain arithmetic reference for one division.
  function automatic res_t model(input logic [61:0] a, input logic [31:0] b);
    res_t        res;
    logic [63:0] m;
    logic [63:0] qq;
    if (b == 32'd0) begin
      res.q = '1;
      res.r = a[31:0];
      res.z = 1'b1;
    end else begin
      m     = b[31] ? (64'd0 - {{32{b[31]}}, b}) : {32'd0, b};
      qq    = {2'b00, a} / m;
      res.r = 32'({2'b00, a} % m);
      res.q = b[31] ? (64'd0 - qq) : qq;
      res.z = 1'b0;
    end
    return res;
  endfunction

  // Transaction-level expectation: busy for a fixed number of ce edges, then one done pulse.
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  int   m_left = 0;
  res_t m_res = '0;
  res_t p_res = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
    end else if (ce) begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_res  <= p_res;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= (din1 == 32'd0) ? 1 : Lat - 1;
        p_res  <= model(din0, din1);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_ready", 64'(ready), 64'(!m_busy));
    chk("cyc_done", 64'(done), 64'(m_done));
    chk("cyc_quot", quot, m_res.q);
    chk("cyc_rem", 64'(rem), 64'(m_res.r));
    chk("cyc_dbz", 64'(dbz), 64'(m_res.z));
  end

  always @(posedge clk) begin
    if (rand_ce) begin
      #1 ce = ($urandom_range(3) != 0);
    end
  end

  task automatic issue(input logic [61:0] a, input logic [31:0] b);
    bit acc;
    int guard;
    din0  = a;
    din1  = b;
    start = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(posedge clk);
      acc = ce;
      guard++;
    end
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accept edge; returns at the falling edge of the done cycle.
  task automatic wait_done(output int c, output bit seen);
    c    = 1;
    seen = 1'b0;
    while (!seen && c < 400) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
  endtask

  task automatic check_res(input string nm, input int c, input bit seen, input logic [63:0] eq,
                           input logic [31:0] er, input logic ez, input int elat);
    chk({nm, "_seen"}, 64'(seen), 64'd1);
    if (elat > 0) chk({nm, "_lat"}, 64'(c), 64'(elat));
    chk({nm, "_quot"}, quot, eq);
    chk({nm, "_rem"}, 64'(rem), 64'(er));
    chk({nm, "_dbz"}, 64'(dbz), 64'(ez));
  endtask

  task automatic do_op(input logic [61:0] a, input logic [31:0] b, input logic [63:0] eq,
                       input logic [31:0] er, input logic ez, input int elat, input string nm);
    int c;
    bit seen;
    issue(a, b);
    wait_done(c, seen);
    check_res(nm, c, seen, eq, er, ez, elat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    int          nd;
    bit          seen;
    logic [61:0] a;
    logic [31:0] b;
    res_t        r;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quot", quot, 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    idle(1);

    do_op(62'd100, 32'd7, 64'd14, 32'd2, 1'b0, 64, "basic");
    idle(2);
    do_op(62'd100, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 32'd2, 1'b0, 64, "negdiv");
    do_op(62'h3FFF_FFFF_FFFF_FFFF, 32'h8000_0000, 64'hFFFF_FFFF_8000_0001, 32'h7FFF_FFFF, 1'b0,
          64, "extreme");
    do_op(62'd0, 32'd5, 64'd0, 32'd0, 1'b0, 64, "zero_dvd");
    idle(1);
    do_op(62'd5, 32'd0, '1, 32'd5, 1'b1, 2, "dbz");
    do_op(62'd100, 32'd7, 64'd14, 32'd2, 1'b0, 64, "after_dbz");
    idle(3);

    // Ten ce-low cycles in the middle of the iteration.
    issue(62'd1000, 32'd33);
    fork
      begin
        repeat (20) @(posedge clk);
        #1 ce = 1'b0;
        repeat (10) @(posedge clk);
        #1 ce = 1'b1;
      end
    join_none
    wait_done(c, seen);
    check_res("stall", c, seen, 64'd30, 32'd10, 1'b0, 74);
    idle(2);

    // A start while busy must neither disturb the result nor produce a second done.
    issue(62'd12345, 32'hFFFF_FF9C);
    fork
      begin
        repeat (10) @(posedge clk);
        #1 din0 = 62'd7;
        din1  = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join_none
    wait_done(c, seen);
    check_res("busy_start", c, seen, 64'hFFFF_FFFF_FFFF_FF85, 32'd45, 1'b0, 64);
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_second_done", 64'(nd), 64'd0);
    idle(1);

    do_op(62'd100, 32'd7, 64'd14, 32'd2, 1'b0, 64, "b2b_first");
    do_op(62'd200, 32'd9, 64'd22, 32'd2, 1'b0, 64, "b2b_second");
    idle(2);

    // Reset in cycle 30 of a division.
    issue(62'd100, 32'd7);
    repeat (29) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_quot", quot, 64'd0);
    chk("midrst_rem", 64'(rem), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    do_op(62'd9, 32'd3, 64'd3, 32'd0, 1'b0, 64, "after_rst");
    idle(1);

    rand_ce = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 62'({$urandom, $urandom} >> ($urandom_range(40)));
      case ($urandom_range(7))
        0:       b = 32'd0;
        1:       b = 32'h8000_0000;
        2:       b = 32'($urandom_range(15, 1));
        3:       b = 32'd0 - 32'($urandom_range(15, 1));
        4:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      r = model(a, b);
      issue(a, b);
      wait_done(c, seen);
      check_res("rand", c, seen, r.q, r.r, r.z, 0);
      repeat ($urandom_range(3)) @(posedge clk);
    end
    rand_ce = 1'b0;
    @(posedge clk);
    #2 ce = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxpooling_div_62ns_32s_64_seq.md
Name: maxpooling_div_62ns_32s_64_seq

Overview:
- Iterative, one-bit-per-cycle restoring divider. It is the inverse of the MaxPooling 62ns x 32s -> 64 pipelined multiplier.
- Divides an unsigned dividend by a signed divisor. Produces a signed quotient and a non-negative remainder.
- Used in the MaxPooling datapath for averaging and normalisation.
- Uses the same clock-enable (ce) semantics as the multiplier cores, plus a start/ready/done handshake.

Parameters:
- ID, 1, instance tag; no functional effect.
- din0_WIDTH, 62, dividend width (unsigned).
- din1_WIDTH, 32, divisor width (signed, two's complement).
- dout_WIDTH, 64, quotient width (signed); must be >= din0_WIDTH+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request; operands are sampled when start=1, ce=1, ready=1.
- din0  in  din0_WIDTH  dividend, unsigned.
- din1  in  din1_WIDTH  divisor, signed.
- ready  out  1  high in IDLE; a start is accepted only then.
- done  out  1  one-ce-cycle pulse; quot/rem/dbz are valid.
- quot  out  dout_WIDTH  signed quotient, truncated toward zero.
- rem  out  din1_WIDTH  remainder; 0 <= rem < |din1|.
- dbz  out  1  divide-by-zero flag; qualified by done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=1, done=0, quot=0, rem=0, dbz=0, counter=0. Reset aborts any division in progress and produces no done.
- States: IDLE, CALC, FIX. All transitions and register updates occur only on edges where ce=1.
- IDLE:
  - On accept, latch the dividend and |din1| into a din1_WIDTH+1 bit magnitude register, so -2^31 gives 2^31. Latch sign = din1[MSB].
  - Clear the partial remainder (din1_WIDTH+1 bits) and set counter=din0_WIDTH.
  - If din1 != 0, go to CALC; if din1 == 0, go to FIX with the dbz flag set.
  - start while not ready, or with ce=0, is ignored and not queued.
- CALC, once per ce edge:
  - pr = {pr, dividend MSB}; shift the dividend left.
  - If pr >= mag: pr -= mag and shift in quotient bit 1; otherwise shift in 0.
  - Decrement counter. The edge on which counter goes 1 -> 0 moves to FIX. This gives exactly din0_WIDTH iterations.
- FIX (one cycle, registers outputs; the next state is always IDLE):
  - Normal case: quot = sign ? -zext(q) : zext(q), two's complement in dout_WIDTH. rem = pr[din1_WIDTH-1:0]. dbz=0. done=1.
  - Divide by zero: quot = all ones, rem = din0[din1_WIDTH-1:0], dbz=1, done=1.
- done is high for exactly one ce cycle, then clears on the next ce edge. With ce=0 it holds high.
- quot, rem and dbz hold until the next FIX.
- Latency, with ce held high and start accepted in cycle 0:
  - Normal: done=1 in cycle din0_WIDTH+2 (64 by default).
  - Divide by zero: done=1 in cycle 2.
  - Each ce=0 cycle adds one cycle of latency.
- Back-to-back operation: ready=1 in the done cycle, so a new start can be accepted there. Its done arrives 64 cycles later.
- The remainder sign follows the dividend, so it is always non-negative. The quotient magnitude is < 2^din0_WIDTH, so negation never overflows.

Test Plan:
- Basic division: din0=100, din1=7, start in cycle 0 -> done=1 in cycle 64 only; quot=14, rem=2, dbz=0; ready=0 in cycles 1-63.
- Negative divisor: din0=100, din1=-7 -> quot=0xFFFF_FFFF_FFFF_FFF2, rem=2.
- Extremes: din0=2^62-1, din1=0x8000_0000 -> quot=0xFFFF_FFFF_8000_0001, rem=0x7FFF_FFFF. Also din0=0, din1=5 -> quot=0, rem=0.
- Divide by zero: din0=5, din1=0 -> done in cycle 2, dbz=1, quot=all ones, rem=5. A following 100/7 -> dbz=0.
- ce stall and busy start:
  - Drop ce for 10 cycles mid-CALC -> done in cycle 74, results unchanged.
  - start during CALC -> ignored, no second done.
  - New start in the done cycle -> accepted; its done arrives 64 cycles later.
- Reset mid-op: assert reset in cycle 30 -> immediately ready=1, done=0, quot=0, rem=0. Release, then 9/3 -> quot=3, rem=0, done in cycle 64 after its start.
